// File: rtl/wc_stream.sv
// Streaming 1-D F(4,3) correlation via Winograd transforms, with CH-tile channel
// accumulation, per-lane output saturation and a ready/valid handshake on both sides.
module wc_stream #(
  parameter int DW = 10,
  parameter int CW = 8,
  parameter int OW = 10,
  parameter int CH = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            coef_we,
  input  logic [3*CW-1:0] coef,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6*DW-1:0] d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*OW-1:0] z,
  output logic [3:0]      sat,
  output logic            busy
);

  localparam int VW = DW + 4;
  localparam int UW = CW + 5;
  localparam int MW = VW + UW;
  localparam int YW = MW + 5;
  localparam int AW = YW + $clog2(CH + 1);
  localparam int NW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [NW-1:0]        LAST = NW'(CH - 1);
  localparam logic signed [YW-1:0] DIV  = YW'(24);
  localparam logic signed [AW-1:0] ZMAX = AW'((2 ** (OW - 1)) - 1);
  localparam logic signed [AW-1:0] ZMIN = AW'(-(2 ** (OW - 1)));

  logic signed [UW-1:0] gx [3];
  logic signed [VW-1:0] dx [6];
  logic signed [YW-1:0] mx [6];
  logic signed [YW-1:0] a   [4];
  logic signed [AW-1:0] sum [4];

  logic signed [UW-1:0] u_q [6], u_d [6];
  logic signed [VW-1:0] v_q [6], v_d [6];
  logic signed [MW-1:0] m_q [6], m_d [6];
  logic signed [YW-1:0] y_q [4], y_d [4];
  logic signed [AW-1:0] acc_q [4], acc_d [4];
  logic [NW-1:0]        cnt_q, cnt_d;
  logic [4*OW-1:0]      z_q, z_d;
  logic [3:0]           sat_q, sat_d;
  logic                 s1_q, s2_q, s3_q, ov_q, rdy_q;
  logic                 stall, coef_ld, accept, last;

  assign busy      = s1_q | s2_q | s3_q | ov_q | (cnt_q != '0);
  assign stall     = ov_q & ~out_ready;
  assign coef_ld   = coef_we & ~busy;
  assign in_ready  = rdy_q & ~stall & ~coef_ld;
  assign accept    = in_valid & in_ready;
  assign last      = (cnt_q == LAST);
  assign out_valid = ov_q;
  assign z         = z_q;
  assign sat       = sat_q;

  // Filter transform is 24*G so U stays integer; the matching /24 happens after A^T.
  always_comb begin
    for (int k = 0; k < 3; k++) gx[k] = UW'(signed'(coef[(2-k)*CW +: CW]));
    for (int k = 0; k < 6; k++) dx[k] = VW'(signed'(d[(5-k)*DW +: DW]));
    u_d[0] = (gx[0] <<< 2) + (gx[0] <<< 1);
    u_d[1] = -((gx[0] + gx[1] + gx[2]) <<< 2);
    u_d[2] = -((gx[0] - gx[1] + gx[2]) <<< 2);
    u_d[3] = gx[0] + (gx[1] <<< 1) + (gx[2] <<< 2);
    u_d[4] = gx[0] - (gx[1] <<< 1) + (gx[2] <<< 2);
    u_d[5] = (gx[2] <<< 4) + (gx[2] <<< 3);
    v_d[0] = (dx[0] <<< 2) - ((dx[2] <<< 2) + dx[2]) + dx[4];
    v_d[1] = -(dx[1] <<< 2) - (dx[2] <<< 2) + dx[3] + dx[4];
    v_d[2] = (dx[1] <<< 2) - (dx[2] <<< 2) - dx[3] + dx[4];
    v_d[3] = -(dx[1] <<< 1) - dx[2] + (dx[3] <<< 1) + dx[4];
    v_d[4] = (dx[1] <<< 1) - dx[2] - (dx[3] <<< 1) + dx[4];
    v_d[5] = (dx[1] <<< 2) - ((dx[3] <<< 2) + dx[3]) + dx[5];
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      m_d[i] = MW'(v_q[i]) * MW'(u_q[i]);
      mx[i]  = YW'(m_q[i]);
    end
    a[0] = mx[0] + mx[1] + mx[2] + mx[3] + mx[4];
    a[1] = mx[1] - mx[2] + (mx[3] <<< 1) - (mx[4] <<< 1);
    a[2] = mx[1] + mx[2] + (mx[3] <<< 2) + (mx[4] <<< 2);
    a[3] = mx[1] - mx[2] + (mx[3] <<< 3) - (mx[4] <<< 3) + mx[5];
    for (int i = 0; i < 4; i++) y_d[i] = a[i] / DIV;
  end

  always_comb begin
    z_d   = '0;
    sat_d = '0;
    cnt_d = last ? '0 : cnt_q + NW'(1);
    for (int i = 0; i < 4; i++) begin
      sum[i]   = acc_q[i] + AW'(y_q[i]);
      acc_d[i] = last ? '0 : sum[i];
      if (sum[i] > ZMAX) begin
        z_d[(3-i)*OW +: OW] = ZMAX[OW-1:0];
        sat_d[3-i]          = 1'b1;
      end else if (sum[i] < ZMIN) begin
        z_d[(3-i)*OW +: OW] = ZMIN[OW-1:0];
        sat_d[3-i]          = 1'b1;
      end else begin
        z_d[(3-i)*OW +: OW] = sum[i][OW-1:0];
      end
    end
  end

  // A held output freezes every stage, so nothing in flight can overtake it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q <= 1'b0;
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      ov_q  <= 1'b0;
      cnt_q <= '0;
      z_q   <= '0;
      sat_q <= '0;
      for (int i = 0; i < 6; i++) begin
        u_q[i] <= '0;
        v_q[i] <= '0;
        m_q[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        y_q[i]   <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      if (coef_ld) u_q <= u_d;
      if (!stall) begin
        s1_q <= accept;
        s2_q <= s1_q;
        s3_q <= s2_q;
        ov_q <= s3_q & last;
        if (accept) v_q <= v_d;
        if (s1_q) m_q <= m_d;
        if (s2_q) y_q <= y_d;
        if (s3_q) begin
          cnt_q <= cnt_d;
          acc_q <= acc_d;
          if (last) begin
            z_q   <= z_d;
            sat_q <= sat_d;
          end
        end
      end
    end
  end

endmodule
